// File: rtl/idex_pkg.sv
// idex_pkg: default widths, EX control bit positions and payload struct for the ID/EX stage
package idex_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 8;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_WB_W   = 2;
  localparam int DEF_M_W    = 3;
  localparam int DEF_CNT_W  = 16;
  localparam int EX_REGDST  = 2;
  localparam int EX_ALUOP   = 1;
  localparam int EX_ALUSRC  = 0;
  typedef struct packed {
    logic [DEF_PC_W-1:0]   nextInst;
    logic [DEF_DATA_W-1:0] regData1;
    logic [DEF_DATA_W-1:0] regData2;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_REG_AW-1:0] rt;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_WB_W-1:0]   WB;
    logic [DEF_M_W-1:0]    M;
    logic [2:0]            EX;
  } idex_payload_t;
endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// id_ex_pipe_stage_if: upstream payload/handshake and EX-side outputs of the ID/EX stage
interface id_ex_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int REG_AW = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int CNT_W  = 16
);
  logic              flush_IDEX;
  logic              in_valid_IDEX;
  logic              in_ready_IDEX;
  logic [PC_W-1:0]   nextInst_IN;
  logic [DATA_W-1:0] regData1_IN;
  logic [DATA_W-1:0] regData2_IN;
  logic [DATA_W-1:0] imm_IN;
  logic [REG_AW-1:0] rt_IN;
  logic [REG_AW-1:0] rd_IN;
  logic [WB_W-1:0]   WB_IN;
  logic [M_W-1:0]    M_IN;
  logic [2:0]        EX_IN;
  logic              out_valid_IDEX;
  logic              out_ready_IDEX;
  logic [PC_W-1:0]   nextInst;
  logic [DATA_W-1:0] regData1;
  logic [DATA_W-1:0] regData2;
  logic [DATA_W-1:0] imm;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [WB_W-1:0]   WB;
  logic [M_W-1:0]    M;
  logic              RegDst;
  logic              ALUOp;
  logic              ALUSrc;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output flush_IDEX, in_valid_IDEX, nextInst_IN, regData1_IN, regData2_IN, imm_IN, rt_IN, rd_IN,
           WB_IN, M_IN, EX_IN, out_ready_IDEX,
    input  in_ready_IDEX, out_valid_IDEX, nextInst, regData1, regData2, imm, rt, rd, WB, M,
           RegDst, ALUOp, ALUSrc, stall_cnt
  );
  modport slave (
    input  flush_IDEX, in_valid_IDEX, nextInst_IN, regData1_IN, regData2_IN, imm_IN, rt_IN, rd_IN,
           WB_IN, M_IN, EX_IN, out_ready_IDEX,
    output in_ready_IDEX, out_valid_IDEX, nextInst, regData1, regData2, imm, rt, rd, WB, M,
           RegDst, ALUOp, ALUSrc, stall_cnt
  );
endinterface

// File: rtl/idex_skid_buf.sv
// idex_skid_buf: single payload entry with valid bit; clear wins over load
module idex_skid_buf
  import idex_pkg::*;
#(
  parameter type T = idex_payload_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_pop,
  input  T     i_d,
  output T     o_q,
  output logic o_valid
);
  logic r_valid;
  T     r_q;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_valid <= 1'b0;
    else if (i_load) r_valid <= 1'b1;
    else if (i_pop) r_valid <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else if (i_load) r_q <= i_d;
  end
  assign o_q = r_q;
  assign o_valid = r_valid;
endmodule

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID/EX register with valid/ready, stall hold, flush-to-bubble and saturating stall counter.
// Define IDEX_SKID_EN for a registered-ready skid entry; otherwise ready is combinational.
module id_ex_pipe_stage
  import idex_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int WB_W   = DEF_WB_W,
  parameter int M_W    = DEF_M_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic clk_IDEX,
  input logic rst_IDEX,
  id_ex_pipe_stage_if.slave bus
);
  typedef struct packed {
    logic [PC_W-1:0]   nextInst;
    logic [DATA_W-1:0] regData1;
    logic [DATA_W-1:0] regData2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [WB_W-1:0]   WB;
    logic [M_W-1:0]    M;
    logic [2:0]        EX;
  } pl_t;
  pl_t              r_pl, w_in, w_next;
  logic             r_valid, w_stall, w_accept, w_next_valid;
  logic [CNT_W-1:0] r_cnt;
  assign w_in = {bus.nextInst_IN, bus.regData1_IN, bus.regData2_IN, bus.imm_IN, bus.rt_IN, bus.rd_IN,
                 bus.WB_IN, bus.M_IN, bus.EX_IN};
  assign w_stall = r_valid & ~bus.out_ready_IDEX;
  assign w_accept = bus.in_valid_IDEX & bus.in_ready_IDEX;
`ifdef IDEX_SKID_EN
  pl_t  w_s_q;
  logic w_s_valid;
  // ready comes straight from the skid valid flop, so it never depends on out_ready
  assign bus.in_ready_IDEX = ~w_s_valid;
  idex_skid_buf #(.T(pl_t)) u_skid (
    .clk(clk_IDEX), .rst(rst_IDEX), .i_clr(bus.flush_IDEX), .i_load(w_accept & w_stall),
    .i_pop(w_s_valid & ~w_stall), .i_d(w_in), .o_q(w_s_q), .o_valid(w_s_valid)
  );
  assign w_next_valid = w_s_valid | w_accept;
  assign w_next = w_s_valid ? w_s_q : w_in;
`else
  assign bus.in_ready_IDEX = ~w_stall;
  assign w_next_valid = w_accept;
  assign w_next = w_in;
`endif
  always_ff @(posedge clk_IDEX) begin
    if (rst_IDEX) begin
      r_valid <= 1'b0;
      r_pl <= '0;
      r_cnt <= '0;
    end else if (bus.flush_IDEX) begin
      r_valid <= 1'b0;
      r_pl.WB <= '0;
      r_pl.M <= '0;
      r_pl.EX <= '0;
    end else begin
      if (w_stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (!w_stall) begin
        r_valid <= w_next_valid;
        if (w_next_valid) r_pl <= w_next;
        else begin
          r_pl.WB <= '0;
          r_pl.M <= '0;
          r_pl.EX <= '0;
        end
      end
    end
  end
  assign bus.out_valid_IDEX = r_valid;
  assign bus.nextInst = r_pl.nextInst;
  assign bus.regData1 = r_pl.regData1;
  assign bus.regData2 = r_pl.regData2;
  assign bus.imm = r_pl.imm;
  assign bus.rt = r_pl.rt;
  assign bus.rd = r_pl.rd;
  assign bus.WB = r_pl.WB;
  assign bus.M = r_pl.M;
  assign bus.RegDst = r_pl.EX[EX_REGDST];
  assign bus.ALUOp = r_pl.EX[EX_ALUOP];
  assign bus.ALUSrc = r_pl.EX[EX_ALUSRC];
  assign bus.stall_cnt = r_cnt;
endmodule
